// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared definitions for the bit-serial ALU
//
// Purpose: op encodings, default operand width and FSM state type used by
// alu_serial8 and its testbench.
// Ports: none (package).
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mux2to1.sv
// rtl/mux2to1.sv - single-bit 2:1 multiplexer
//
// Purpose: selects I1 when S is high, I0 otherwise.
// Ports:
//   S  - select
//   I0 - input chosen when S=0
//   I1 - input chosen when S=1
//   Y  - selected output
module mux2to1 (
  input  logic S,
  input  logic I0,
  input  logic I1,
  output logic Y
);

  assign Y = S ? I1 : I0;

endmodule

// File: rtl/alu_serial8.sv
// rtl/alu_serial8.sv - bit-serial ADD/SUB/AND/OR ALU, one bit per clock
//
// Purpose: on an accepted start the operands and op are captured, then one
// result bit is produced per cycle LSB first; done pulses for one cycle when
// the full result is in y. Optional zero flag output z is built only when the
// macro ALU_SERIAL_ZERO_FLAG_EN is defined.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   start - begin an operation (sampled in IDLE and DONE only)
//   op    - 00 ADD, 01 SUB, 10 AND, 11 OR
//   a, b  - operands (WIDTH bits)
//   busy  - high while bits are being processed
//   done  - one-cycle result-valid pulse
//   y     - result, stable from done until the next accepted start
//   cout  - carry (ADD), no-borrow (SUB), 0 for logic ops
//   z     - (ALU_SERIAL_ZERO_FLAG_EN only) 1 iff y==0, valid from done
module alu_serial8
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  ,
  output logic             z
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             z_q, z_d;
`endif

  logic a_bit, b_bit, b_eff;
  logic sum_bit, carry_nx, logic_bit, res_bit;

  // Current bit slice of the captured operands; SUB is a + ~b + 1, with the
  // +1 coming from the carry preset on start.
  assign a_bit     = a_q[idx_q];
  assign b_bit     = b_q[idx_q];
  assign b_eff     = (op_q == OP_SUB) ? ~b_bit : b_bit;
  assign sum_bit   = a_bit ^ b_eff ^ carry_q;
  assign carry_nx  = (a_bit & b_eff) | (carry_q & (a_bit ^ b_eff));
  assign logic_bit = op_q[0] ? (a_bit | b_bit) : (a_bit & b_bit);

  // op[1] separates logic ops from arithmetic ones.
  mux2to1 u_sel (
    .S  (op_q[1]),
    .I0 (sum_bit),
    .I1 (logic_bit),
    .Y  (res_bit)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    y_d     = y_q;
    cout_d  = cout_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    z_d     = z_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = (op == OP_SUB);
          y_d     = '0;
          cout_d  = 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          z_d     = 1'b0;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        y_d[idx_q] = res_bit;
        carry_d    = carry_nx;
        idx_d      = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = op_q[1] ? 1'b0 : carry_nx;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          z_d     = (y_d == '0);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      z_q     <= z_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign y    = y_q;
  assign cout = cout_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  assign z    = z_q;
`endif

endmodule

// File: tb/tb_alu_serial8.sv
// tb/tb_alu_serial8.sv - scoreboard testbench for alu_serial8
module tb_alu_serial8;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] y;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic         z;
`endif

  alu_serial8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .cout  (cout)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    ,
    .z     (z)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    int           edge_n;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int busy_run = 0;
  logic [W-1:0] last_y = '0;
  logic         last_c = 1'b0;
  bit           have_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] v, input int e);
    exp_t r;
    int unsigned s;
    s = 0;
    case (o)
      OP_ADD: begin s = 32'(x) + 32'(v); r.y = W'(s); r.c = (s >= (32'd1 << W)); end
      OP_SUB: begin r.y = x - v; r.c = (x >= v); end
      OP_AND: begin r.y = x & v; r.c = 1'b0; end
      default: begin r.y = x | v; r.c = 1'b0; end
    endcase
    r.z = (r.y == '0);
    r.edge_n = e;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op that is sampled at the next edge; returns with the DUT in DONE.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] v, input bit disturb);
    start = 1'b1; op = o; a = x; b = v;
    q.push_back(model(o, x, v, cyc + 1));
    tick();
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (disturb) begin
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        start = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      have_last = 1'b0;
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        done_count++;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("y", 32'(y), 32'(e.y));
          chk("cout", 32'(cout), 32'(e.c));
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          chk("z", 32'(z), 32'(e.z));
`endif
          chk("latency", 32'(cyc), 32'(e.edge_n + W));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("busy_cycles", 32'(busy_run), 32'(W));
          last_y = e.y;
          last_c = e.c;
          have_last = 1'b1;
        end
        busy_run = 0;
      end else begin
        if (q.size() > 0 && cyc > q[0].edge_n + W) begin
          chk("done_missing", 32'd0, 32'd1);
          e = q.pop_front();
        end
        if (have_last && !busy) begin
          chk("y_hold", 32'(y), 32'(last_y));
          chk("cout_hold", 32'(cout), 32'(last_c));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dc;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk("rst_z", 32'(z), 32'd0);
`endif
    reset = 1'b0;
    tick();

    issue(OP_ADD, 8'h0F, 8'h01, 1'b0); repeat (2) tick();
    issue(OP_ADD, 8'hFF, 8'h01, 1'b0); repeat (2) tick();
    issue(OP_SUB, 8'h05, 8'h07, 1'b0); repeat (2) tick();
    issue(OP_SUB, 8'h07, 8'h05, 1'b0); repeat (2) tick();
    issue(OP_AND, 8'hF0, 8'h3C, 1'b0);
    issue(OP_OR,  8'hF0, 8'h3C, 1'b0); repeat (2) tick();
    issue(OP_ADD, 8'h12, 8'h34, 1'b1); repeat (2) tick();

    // Reset during the 4th RUN cycle aborts the op.
    start = 1'b1; op = OP_ADD; a = 8'h5A; b = 8'h33;
    q.push_back(model(OP_ADD, 8'h5A, 8'h33, cyc + 1));
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    q.delete();
    dc = done_count;
    repeat (2) tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("no_done_after_reset", 32'(done_count), 32'(dc));

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom);
      ra = ($urandom % 5 == 0) ? 8'hFF : W'($urandom);
      rb = ($urandom % 5 == 0) ? 8'h00 : W'($urandom);
      issue(ro, ra, rb, ($urandom % 3) == 0);
      if ($urandom % 2 == 0) repeat ($urandom_range(1, 3)) tick();
    end
    repeat (5) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_serial8.md
ALU_SERIAL8 -- requirements
Module: alu_serial8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1: request to begin an operation.
REQ-005 The block SHALL have port op, input, 2: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-006 The block SHALL have port a, input, WIDTH: operand A.
REQ-007 The block SHALL have port b, input, WIDTH: operand B.
REQ-008 The block SHALL have port busy, output, 1: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port y, output, WIDTH: result, held stable from done until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1: carry-out for ADD; no-borrow flag for SUB; 0 for AND and OR.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 start SHALL be sampled only in IDLE or DONE; the block SHALL ignore start while in RUN.
REQ-014 On an accepted start, the block SHALL capture a, b and op, load the bit index to 0, load carry (1 for SUB, else 0), and enter RUN.
REQ-015 In RUN, each cycle the block SHALL process one bit, LSB first: bit i of y is the mux2to1 output with S=op[1], I0=sum bit, I1=logic bit.
REQ-016 The sum bit SHALL be a[i]^b'[i]^carry, where b'=~b for SUB and b otherwise; carry SHALL update to the full-adder carry.
REQ-017 The logic bit SHALL be a[i]|b[i] when op[0]=1 and a[i]&b[i] otherwise.
REQ-018 After bit WIDTH-1, the block SHALL go RUN->DONE; done=1 for exactly the one DONE cycle, then DONE->IDLE unless start is accepted.
REQ-019 The latency from the start-sampling edge to done high SHALL be WIDTH+1 rising edges (9 for WIDTH=8).
REQ-020 start sampled in DONE SHALL go DONE->RUN directly, giving back-to-back operations with no IDLE cycle.
REQ-021 busy SHALL be 1 in RUN, 0 in IDLE and DONE.
REQ-022 y and cout SHALL change only during RUN and SHALL be cleared when start is accepted.
REQ-023 Changes on a, b or op during RUN SHALL NOT affect the result.

Reset
REQ-024 While reset is high, the block SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, y=0, cout=0, bit index=0 and carry=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-026 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-027 When the macro ALU_SERIAL_ZERO_FLAG_EN is defined, the block SHALL have an extra output port z (1 bit) that equals 1 iff y==0, is valid from done onward, and resets to 0.
REQ-028 When ALU_SERIAL_ZERO_FLAG_EN is not defined, port z and its logic SHALL be absent.

Structure
REQ-029 The shared package alu_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_AND, OP_OR), the default WIDTH constant and the FSM state type.
REQ-030 The block SHALL instantiate exactly one existing mux2to1 as its per-bit result selector, with port order (S, I0, I1, Y); there SHALL be no other sub-modules.

Verification
REQ-031 The bench SHALL check ADD a=0x0F, b=0x01 -> at the 9th edge done=1, y=0x10, cout=0, busy was 1 for 8 cycles.
REQ-032 The bench SHALL check ADD a=0xFF, b=0x01 -> y=0x00, cout=1, and z=1 when the macro is defined.
REQ-033 The bench SHALL check SUB a=0x05, b=0x07 -> y=0xFE, cout=0; and SUB a=0x07, b=0x05 -> y=0x02, cout=1.
REQ-034 The bench SHALL check AND a=0xF0, b=0x3C -> y=0x30, cout=0; then start in the DONE cycle with OR on the same operands -> y=0xFC, 9 edges later.
REQ-035 The bench SHALL check that start pulsed with different operands during RUN is ignored and the original result is delivered.
REQ-036 The bench SHALL check reset asserted at the 4th RUN cycle -> busy=0, y=0, cout=0 immediately, and no done pulse follows.
